seq_event_monitor: RTL and testbench

//  Downstream consumer of the Moore sequence detector's single-bit match output.
//  - Rising-edge-qualifies each detection and keeps a saturating lifetime count.
//  - Raises alarm when THRESH detections land inside a sliding-start window of WIN_LEN cycles.
//  - Overlapping matches (det_in 1,0,1) count as two events.

---
 rtl/seq_event_monitor_pkg.sv | 19 +
 rtl/seq_event_monitor_rise_edge_det.sv | 20 ++
 rtl/seq_event_monitor.sv | 127 ++++++++++++
 tb/tb_seq_event_monitor.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_event_monitor_pkg.sv
// Shared encodings and sizing helpers for the sequence event monitor.
package seq_event_monitor_pkg;

  localparam int unsigned ST_W      = 2;
  localparam int unsigned WIN_CNT_W = 8;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_WINDOW = 2'd1,
    ST_ALARM  = 2'd2,
    ST_RSVD   = 2'd3
  } state_t;

  // Window timer only has to hold WIN_LEN-1.
  function automatic int unsigned timer_w(input int unsigned win_len);
    return (win_len < 2) ? 1 : $clog2(win_len);
  endfunction

endpackage

// File: rtl/seq_event_monitor_rise_edge_det.sv
// Registered copy of a detector output plus its rising-edge term.
module rise_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q_d,
  output logic rise
);

  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= 1'b0;
    else     r_q <= d;
  end

  assign q_d  = r_q;
  assign rise = d & ~r_q;

endmodule

// File: rtl/seq_event_monitor.sv
// Event monitor: rising-edge event count plus windowed threshold alarm.
// Build option: define ALARM_LATCH_EN to make the alarm sticky until clr/rst.
module seq_event_monitor
  import seq_event_monitor_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned WIN_LEN = 16,
  parameter int unsigned THRESH  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 det_in,
  input  logic                 clr,
  output logic                 evt_pulse,
  output logic [CNT_W-1:0]     total_cnt,
  output logic [WIN_CNT_W-1:0] win_cnt,
  output logic                 alarm
);

  localparam int unsigned           TW           = timer_w(WIN_LEN);
  localparam logic [TW-1:0]         TIMER_RELOAD = TW'(WIN_LEN - 1);
  localparam logic [WIN_CNT_W-1:0]  THRESH_V     = WIN_CNT_W'(THRESH);
  localparam bit                    START_ALARM  = (THRESH <= 1);

  logic                 w_det_q, w_evt;
  state_t               r_state, w_state_nxt;
  logic [TW-1:0]        r_timer, w_timer_nxt;
  logic [WIN_CNT_W-1:0] r_win, w_win_nxt, w_win_inc;
  logic                 r_alarm, w_alarm_nxt;
  logic [CNT_W-1:0]     r_total;
  logic                 r_evt;

  rise_edge_det u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (det_in),
    .q_d  (w_det_q),
    .rise (w_evt)
  );

  always_comb assert (!(w_evt && w_det_q));

  assign w_win_inc = (r_win == '1) ? r_win : r_win + WIN_CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_win_nxt   = r_win;
    w_alarm_nxt = r_alarm;
    case (r_state)
      ST_IDLE: begin
        if (w_evt) begin
          w_state_nxt = START_ALARM ? ST_ALARM : ST_WINDOW;
          w_win_nxt   = WIN_CNT_W'(1);
          w_timer_nxt = TIMER_RELOAD;
          w_alarm_nxt = START_ALARM;
        end
      end
      ST_WINDOW, ST_ALARM: begin
`ifdef ALARM_LATCH_EN
        if (r_state == ST_ALARM) begin
          if (w_evt) w_win_nxt = w_win_inc;
        end else
`endif
        // Expiry beats threshold: an event on the expiry edge opens a fresh window.
        if (r_timer == '0) begin
          w_alarm_nxt = 1'b0;
          if (w_evt) begin
            w_state_nxt = START_ALARM ? ST_ALARM : ST_WINDOW;
            w_win_nxt   = WIN_CNT_W'(1);
            w_timer_nxt = TIMER_RELOAD;
            w_alarm_nxt = START_ALARM;
          end else begin
            w_state_nxt = ST_IDLE;
            w_win_nxt   = '0;
          end
        end else begin
          w_timer_nxt = r_timer - TW'(1);
          if (w_evt) begin
            w_win_nxt = w_win_inc;
            if (w_win_inc >= THRESH_V) begin
              w_state_nxt = ST_ALARM;
              w_alarm_nxt = 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
        w_win_nxt   = '0;
        w_alarm_nxt = 1'b0;
      end
    endcase
    if (clr) begin
      w_state_nxt = ST_IDLE;
      w_timer_nxt = '0;
      w_win_nxt   = '0;
      w_alarm_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_win   <= '0;
      r_alarm <= 1'b0;
      r_total <= '0;
      r_evt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_win   <= w_win_nxt;
      r_alarm <= w_alarm_nxt;
      r_evt   <= w_evt & ~clr;
      if (clr)                         r_total <= '0;
      else if (w_evt && r_total != '1) r_total <= r_total + CNT_W'(1);
    end
  end

  assign evt_pulse = r_evt;
  assign total_cnt = r_total;
  assign win_cnt   = r_win;
  assign alarm     = r_alarm;

endmodule

// File: tb/tb_seq_event_monitor.sv
// Bench for seq_event_monitor: vector table, corner sequences, random vs. model.
module tb_seq_event_monitor;

  localparam int WIN = 16;
  localparam int TH  = 3;
`ifdef ALARM_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic       clk, rst, det_in, clr;
  logic       evt_pulse, evt2, alarm, al2;
  logic [7:0] total_cnt, win_cnt, win2;
  logic [1:0] tot2;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  bit m_prev, m_act, m_al, m_ep;
  int m_t = 0, m_s = 0, m_wc = 0, m_tot = 0, m_tot2 = 0;

  seq_event_monitor dut (
    .clk(clk), .rst(rst), .det_in(det_in), .clr(clr),
    .evt_pulse(evt_pulse), .total_cnt(total_cnt), .win_cnt(win_cnt), .alarm(alarm)
  );

  seq_event_monitor #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .det_in(det_in), .clr(clr),
    .evt_pulse(evt2), .total_cnt(tot2), .win_cnt(win2), .alarm(al2)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_act = 0; m_al = 0; m_ep = 0;
    m_wc = 0; m_tot = 0; m_tot2 = 0;
  endtask

  // Drive at negedge, advance one clock, update model, return at next negedge.
  task automatic tick(input bit d, input bit c);
    bit e;
    det_in = d;
    clr    = c;
    @(posedge clk);
    e = d & ~m_prev;
    m_prev = d;
    m_t++;
    if (c) begin
      m_act = 0; m_al = 0; m_wc = 0; m_tot = 0; m_tot2 = 0; m_ep = 0;
    end else begin
      m_ep = e;
      if (e) begin
        if (m_tot < 255) m_tot++;
        if (m_tot2 < 3) m_tot2++;
      end
      if (m_act && !(m_al && LATCH) && (m_t - m_s) >= WIN) begin
        m_act = 0; m_al = 0; m_wc = 0;
      end
      if (e) begin
        if (!m_act) begin
          m_act = 1; m_s = m_t; m_wc = 1; m_al = (TH <= 1);
        end else begin
          if (m_wc < 255) m_wc++;
          if (m_wc >= TH) m_al = 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".evt"},   int'(evt_pulse), int'(m_ep));
    chk({tag, ".total"}, int'(total_cnt), m_tot);
    chk({tag, ".win"},   int'(win_cnt),   m_wc);
    chk({tag, ".alarm"}, int'(alarm),     int'(m_al));
    chk({tag, ".total2"}, int'(tot2),     m_tot2);
    chk({tag, ".evt2"},  int'(evt2),      int'(m_ep));
  endtask

  typedef struct {
    bit det; bit clr; bit evt; int tot; int win; bit al;
  } vec_t;
  vec_t vecs[12];

  initial begin
    int dens;
    vecs[0]  = '{0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 1, 1, 1, 0};
    vecs[2]  = '{0, 0, 0, 1, 1, 0};
    vecs[3]  = '{1, 0, 1, 2, 2, 0};
    vecs[4]  = '{1, 0, 0, 2, 2, 0};
    vecs[5]  = '{1, 0, 0, 2, 2, 0};
    vecs[6]  = '{0, 0, 0, 2, 2, 0};
    vecs[7]  = '{1, 0, 1, 3, 3, 1};
    vecs[8]  = '{0, 0, 0, 3, 3, 1};
    vecs[9]  = '{1, 1, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 0, 0, 0, 0};
    vecs[11] = '{1, 0, 1, 1, 1, 0};

    // reset with det_in toggling
    rst = 1'b1; clr = 1'b0; det_in = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      #2;
      det_in = ~det_in;
      chk("rst.evt",   int'(evt_pulse), 0);
      chk("rst.total", int'(total_cnt), 0);
      chk("rst.win",   int'(win_cnt),   0);
      chk("rst.alarm", int'(alarm),     0);
      #3;
    end
    rst = 1'b0; det_in = 1'b0;

    for (int i = 0; i < 12; i++) begin
      tick(vecs[i].det, vecs[i].clr);
      chk($sformatf("vec%0d.evt", i),   int'(evt_pulse), int'(vecs[i].evt));
      chk($sformatf("vec%0d.total", i), int'(total_cnt), vecs[i].tot);
      chk($sformatf("vec%0d.win", i),   int'(win_cnt),   vecs[i].win);
      chk($sformatf("vec%0d.alarm", i), int'(alarm),     int'(vecs[i].al));
    end

    // event exactly at window expiry opens a new window; idle expiry clears
    tick(0, 1);
    tick(1, 0);
    for (int k = 1; k < 16; k++) tick(0, 0);
    chk("exp.win_before", int'(win_cnt), 1);
    tick(1, 0);
    chk("exp.evt",   int'(evt_pulse), 1);
    chk("exp.win",   int'(win_cnt),   1);
    chk("exp.alarm", int'(alarm),     0);
    chk("exp.total", int'(total_cnt), 2);
    for (int k = 1; k < 16; k++) tick(0, 0);
    chk("idle.win_before", int'(win_cnt), 1);
    tick(0, 0);
    chk("idle.win_after", int'(win_cnt), 0);

    // three events in window -> alarm on edge sampling the third
    tick(0, 1);
    tick(1, 0); tick(0, 0); tick(1, 0); tick(0, 0);
    chk("alm.pre", int'(alarm), 0);
    tick(1, 0);
    chk("alm.set", int'(alarm), 1);
    chk("alm.win", int'(win_cnt), 3);
    for (int k = 5; k < 16; k++) tick(0, 0);
    chk("alm.hold", int'(alarm), 1);
    tick(0, 0);
    chk("alm.expire", int'(alarm), int'(LATCH));
    chk("alm.expire_win", int'(win_cnt), LATCH ? 3 : 0);
    for (int k = 0; k < 100; k++) tick(0, 0);
    chk("alm.long", int'(alarm), int'(LATCH));
    tick(0, 1);
    chk("alm.clr", int'(alarm), 0);

    // held high five cycles counts once
    tick(1, 0);
    chk("hold.evt0", int'(evt_pulse), 1);
    for (int k = 1; k < 5; k++) begin
      tick(1, 0);
      chk("hold.evtN", int'(evt_pulse), 0);
    end
    tick(0, 0);
    chk("hold.total", int'(total_cnt), 1);

    // narrow counter saturates; clr beats a coincident event
    tick(0, 1);
    for (int k = 0; k < 5; k++) begin
      tick(1, 0);
      tick(0, 0);
    end
    chk("sat.total2", int'(tot2), 3);
    chk("sat.total",  int'(total_cnt), 5);
    tick(1, 1);
    chk("sat.clr_total2", int'(tot2), 0);
    chk("sat.clr_evt2",   int'(evt2), 0);
    chk("sat.clr_evt",    int'(evt_pulse), 0);
    tick(0, 0);

    // random traffic against the model, with an async reset mid-run
    for (int i = 0; i < 3000; i++) begin
      dens = ((i / 300) % 3 == 0) ? 6 : (((i / 300) % 3 == 1) ? 20 : 50);
      tick($urandom_range(0, 99) < dens, $urandom_range(0, 249) == 0);
      chk_model("rnd");
      if (i == 1507) begin
        #2 rst = 1'b1;
        #1;
        chk("amr.evt",   int'(evt_pulse), 0);
        chk("amr.total", int'(total_cnt), 0);
        chk("amr.win",   int'(win_cnt),   0);
        chk("amr.alarm", int'(alarm),     0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
